// File: rtl/mem_arbiter.sv
// Two-port line-transfer arbiter: an instruction-cache read port and a data-cache read/writeback port
// share one physical memory. Each grant runs to completion and then takes one DONE cycle before returning to IDLE.
module mem_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_last_d;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_i_rdata;
  logic [LINE_W-1:0]   r_d_rdata;
  logic                r_mem_read;
  logic                r_mem_write;
  logic                r_i_resp;
  logic                r_d_resp;

  logic w_d_pend;
  logic w_grant_d;

  // With both ports pending, D wins unless it had the previous grant.
  assign w_d_pend  = d_read | d_write;
  assign w_grant_d = w_d_pend & (~i_read | ~r_last_d);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_i_resp    <= 1'b0;
      r_d_resp    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            // Writeback takes priority over a simultaneous read on the D port.
            r_state     <= SERVE_D;
            r_addr      <= d_addr;
            r_write     <= d_write;
            r_wdata     <= d_wdata;
            r_mem_read  <= ~d_write;
            r_mem_write <= d_write;
          end else if (i_read) begin
            r_state     <= SERVE_I;
            r_addr      <= i_addr;
            r_write     <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
          end
        end
        SERVE_I: begin
          if (mem_resp) begin
            r_i_rdata   <= mem_rdata;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_i_resp    <= 1'b1;
            r_last_d    <= 1'b0;
            r_state     <= DONE_I;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            if (!r_write) begin
              r_d_rdata <= mem_rdata;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_d_resp    <= 1'b1;
            r_last_d    <= 1'b1;
            r_state     <= DONE_D;
          end
        end
        DONE_I: begin
          r_i_resp <= 1'b0;
          r_state  <= IDLE;
        end
        DONE_D: begin
          r_d_resp <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_i_resp    <= 1'b0;
          r_d_resp    <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign i_rdata   = r_i_rdata;
  assign i_resp    = r_i_resp;
  assign d_rdata   = r_d_rdata;
  assign d_resp    = r_d_resp;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, arbitration order, writeback, stray mem_resp and mid-transfer reset.
module tb_mem_arbiter;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  int vectors = 0;
  int miscompares = 0;
  logic [LINE_W-1:0] exp_i_rdata;
  logic [LINE_W-1:0] exp_d_rdata;

  mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle with the request already driven. mode: 0 keep request,
  // 1 drop it in the DONE cycle, 2 drop it after the first strobe cycle.
  task automatic serve(input string tag, input bit is_d, input bit is_wr,
                       input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                       input logic [LINE_W-1:0] rdata, input int lat, input int mode);
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (mode == 2 && c == 1) begin
        if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
        else i_read = 1'b0;
      end
      chk({tag, "_mem_read"}, mem_read, !is_wr);
      chk({tag, "_mem_write"}, mem_write, is_wr);
      chk({tag, "_mem_addr"}, mem_addr, addr);
      if (is_wr) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
      chk({tag, "_resp_early"}, {i_resp, d_resp}, 2'b00);
    end
    mem_resp  = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_resp = 1'b0;
    if (mode == 1) begin
      if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
      else i_read = 1'b0;
    end
    if (!is_wr) begin
      if (is_d) exp_d_rdata = rdata;
      else exp_i_rdata = rdata;
    end
    chk({tag, "_resp"}, {i_resp, d_resp}, is_d ? 2'b01 : 2'b10);
    chk({tag, "_strobes_done"}, {mem_read, mem_write}, 2'b00);
    chk({tag, "_i_rdata"}, i_rdata, exp_i_rdata);
    chk({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
    tick();
    chk({tag, "_resp_after"}, {i_resp, d_resp}, 2'b00);
    chk({tag, "_strobes_idle"}, {mem_read, mem_write}, 2'b00);
  endtask

  initial begin
    reset_n = 1'b0;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;

    // Reset state
    tick();
    tick();
    chk("rst_strobes", {mem_read, mem_write}, 2'b00);
    chk("rst_resp", {i_resp, d_resp}, 2'b00);
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    reset_n = 1'b1;
    tick();

    // I-cache read, mem_resp at cycle 4
    i_read = 1'b1; i_addr = 16'h1230;
    serve("iread", 1'b0, 1'b0, 16'h1230, '0, {16{8'hA5}}, 4, 1);

    // Writeback; memory drives junk rdata which must not reach d_rdata
    d_write = 1'b1; d_addr = 16'h4000;
    d_wdata = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    serve("dwrite", 1'b1, 1'b1, 16'h4000, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF,
          {4{32'hDEAD_BEEF}}, 3, 1);

    // Stray mem_resp in IDLE is ignored
    mem_resp = 1'b1; mem_rdata = {8{16'h5A5A}};
    tick();
    mem_resp = 1'b0;
    chk("stray_i_rdata", i_rdata, exp_i_rdata);
    chk("stray_d_rdata", d_rdata, exp_d_rdata);
    chk("stray_resp", {i_resp, d_resp}, 2'b00);
    tick();
    chk("stray_strobes", {mem_read, mem_write}, 2'b00);

    // Re-reset so last_grant starts at I, then both ports held: D, I, D, I
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    tick();
    i_read = 1'b1; i_addr = 16'h1100;
    d_read = 1'b1; d_addr = 16'h2200;
    serve("arb1_d", 1'b1, 1'b0, 16'h2200, '0, {4{32'h1111_0001}}, 2, 0);
    serve("arb2_i", 1'b0, 1'b0, 16'h1100, '0, {4{32'h2222_0002}}, 2, 0);
    serve("arb3_d", 1'b1, 1'b0, 16'h2200, '0, {4{32'h3333_0003}}, 1, 1);
    serve("arb4_i", 1'b0, 1'b0, 16'h1100, '0, {4{32'h4444_0004}}, 1, 1);

    // d_read and d_write together: write only
    d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0ABC; d_wdata = {8{16'hC0DE}};
    serve("rdwr", 1'b1, 1'b1, 16'h0ABC, {8{16'hC0DE}}, {4{32'hFFFF_0000}}, 2, 1);

    // I request dropped mid-access still completes
    i_read = 1'b1; i_addr = 16'h7770;
    serve("idrop", 1'b0, 1'b0, 16'h7770, '0, {4{32'h7777_1234}}, 3, 2);

    // Reset during SERVE_D, late mem_resp afterwards
    d_read = 1'b1; d_addr = 16'h3300;
    tick();
    chk("mrst_strobe", mem_read, 1'b1);
    reset_n = 1'b0;
    d_read = 1'b0;
    tick();
    chk("mrst_strobes", {mem_read, mem_write}, 2'b00);
    chk("mrst_resp", {i_resp, d_resp}, 2'b00);
    chk("mrst_addr", mem_addr, '0);
    chk("mrst_wdata", mem_wdata, '0);
    chk("mrst_i_rdata", i_rdata, '0);
    reset_n = 1'b1;
    mem_resp = 1'b1; mem_rdata = {4{32'hBAD0_BAD0}};
    tick();
    mem_resp = 1'b0;
    chk("mrst_late_resp", {i_resp, d_resp}, 2'b00);
    chk("mrst_late_d_rdata", d_rdata, '0);
    chk("mrst_late_strobes", {mem_read, mem_write}, 2'b00);
    tick();
    chk("mrst_final_resp", {i_resp, d_resp}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 128, bit width of one cache line / memory transfer.
REQ-002 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port i_read  input  1  instruction-cache line-read request, held until i_resp.
REQ-006 SHALL have port i_addr  input  ADDR_W  instruction-cache line address.
REQ-007 SHALL have port i_rdata  output  LINE_W  line returned to instruction cache.
REQ-008 SHALL have port i_resp  output  1  one-cycle completion pulse to instruction cache.
REQ-009 SHALL have port d_read  input  1  data-cache line-read request, held until d_resp.
REQ-010 SHALL have port d_write  input  1  data-cache line-writeback request, held until d_resp.
REQ-011 SHALL have port d_addr  input  ADDR_W  data-cache line address.
REQ-012 SHALL have port d_wdata  input  LINE_W  writeback line.
REQ-013 SHALL have port d_rdata  output  LINE_W  line returned to data cache.
REQ-014 SHALL have port d_resp  output  1  one-cycle completion pulse to data cache.
REQ-015 SHALL have port mem_read  output  1  physical-memory read strobe.
REQ-016 SHALL have port mem_write  output  1  physical-memory write strobe.
REQ-017 SHALL have port mem_addr  output  ADDR_W  physical-memory address.
REQ-018 SHALL have port mem_wdata  output  LINE_W  physical-memory write data.
REQ-019 SHALL have port mem_rdata  input  LINE_W  physical-memory read data, valid with mem_resp.
REQ-020 SHALL have port mem_resp  input  1  physical memory done; one-cycle pulse.

Function
REQ-021 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D.
REQ-022 In IDLE, only i_read pending -> SERVE_I; only d_read|d_write pending -> SERVE_D; none -> stay IDLE.
REQ-023 In IDLE, both pending: grant D unless last_grant==D, then grant I (alternating; last_grant reset to I).
REQ-024 On entering SERVE_x, SHALL latch address, direction (read/write) and d_wdata into internal registers; mem_* outputs driven from latched values only.
REQ-025 In SERVE_x, mem_read (or mem_write) SHALL be held high continuously until the cycle mem_resp=1; exactly one of mem_read/mem_write high, never both.
REQ-026 d_read and d_write both high in IDLE: write SHALL win.
REQ-027 On mem_resp in SERVE_x: capture mem_rdata into x_rdata register, go to DONE_x, update last_grant.
REQ-028 In DONE_x: x_resp=1 for exactly one cycle, mem strobes low, then unconditional return to IDLE (one dead cycle so requester can drop request).
REQ-029 Latency: request seen in IDLE at cycle 0 -> strobe from cycle 1; mem_resp at cycle k -> x_resp at cycle k+1 -> IDLE at k+2.
REQ-030 Requester dropping request mid-SERVE SHALL NOT abort: memory access completes and x_resp still pulses.
REQ-031 mem_resp outside SERVE_x SHALL be ignored (no state or data change).
REQ-032 i_rdata/d_rdata SHALL hold last captured value until next capture for that port; d_rdata unchanged after a write.
REQ-033 Requests changing while the other port is served SHALL wait; no request is lost while held.

Reset
REQ-034 reset_n=0 at a rising clk edge SHALL force IDLE, last_grant=I, all outputs 0 (strobes, resp, rdata, addr, wdata), including mid-transaction; the in-flight access is abandoned and a late mem_resp is ignored per REQ-031.

Verification
REQ-035 i_read=1, i_addr=0x1230; mem_resp at cycle 4 with rdata=0xA5..A5 -> mem_read cycles 1-4, mem_addr=0x1230, i_resp=1 cycle 5 only, i_rdata=0xA5..A5.
REQ-036 i_read and d_read both high from reset -> D served first (mem_addr=d_addr), then I; with both held continuously, grants alternate D,I,D,I.
REQ-037 d_write=1, d_addr=0x4000, d_wdata=0x0123..; mem_resp cycle 3 -> mem_write cycles 1-3, mem_read never high, d_resp cycle 4, d_rdata unchanged.
REQ-038 d_read=d_write=1 -> mem_write only; i_read dropped mid-SERVE_I -> i_resp still pulses.
REQ-039 reset_n=0 during SERVE_D, mem_resp next cycle -> all outputs 0, state IDLE, no d_resp.
